// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 16;
  localparam int unsigned DEF_NUM_RD   = 3;

  // Post-reset clear sequencer states
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: zeroes one storage word per cycle from index 0.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned  NUM_REGS       = DEF_NUM_REGS,
  parameter bit           CLEAR_ON_RESET = 1'b1,
  localparam int unsigned ADDR_W         = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  // Last storage index; the PC alias slot has no storage to clear
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 2);

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;

  // State and sweep index registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= CLEAR_ON_RESET ? CLEAR : READY;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state: walk the index upward, leave CLEAR after the last word
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      CLEAR: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = READY;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + ADDR_W'(1);
        end
      end
      READY: begin
        w_state_nxt = READY;
      end
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    o_busy     = 1'b0;
    o_clr_we   = 1'b0;
    o_clr_addr = r_idx;
    if (r_state == CLEAR) begin
      o_busy   = 1'b1;
      o_clr_we = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports,
// top index aliased to an external PC value, optional same-cycle forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned  DATA_W         = DEF_DATA_W,
  parameter int unsigned  NUM_REGS       = DEF_NUM_REGS,
  parameter int unsigned  NUM_RD         = DEF_NUM_RD,
  parameter bit           BYPASS         = 1'b1,
  parameter bit           CLEAR_ON_RESET = 1'b1,
  localparam int unsigned ADDR_W         = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we3,
  input  logic [ADDR_W-1:0]             wa3,
  input  logic [DATA_W-1:0]             wd3,
  input  logic                          web,
  input  logic [ADDR_W-1:0]             wab,
  input  logic [DATA_W-1:0]             wdb,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0]             r15,
  output logic [NUM_RD-1:0][DATA_W-1:0] rd,
  output logic                          busy
);

  localparam int unsigned       NUM_STORE = NUM_REGS - 1;
  localparam logic [ADDR_W-1:0] PC_IDX    = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] r_mem [NUM_STORE];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_a_en;
  logic              w_b_en;

  regfile_clear_fsm #(
    .NUM_REGS       (NUM_REGS),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign busy = w_busy;

  // Write qualification: storage-backed address only, port A wins collisions
  always_comb begin
    w_a_en = 1'b0;
    w_b_en = 1'b0;
    w_a_en = we3 && rst_n && !w_busy && (32'(wa3) < NUM_STORE);
    w_b_en = web && rst_n && !w_busy && (32'(wab) < NUM_STORE)
             && !(we3 && (wa3 == wab));
  end

  // Storage update: clear sweep, then port A, then port B; frozen during reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < NUM_STORE; i++) begin
        if (w_clr_we && (w_clr_addr == ADDR_W'(i))) begin
          r_mem[i] <= '0;
        end else if (w_a_en && (wa3 == ADDR_W'(i))) begin
          r_mem[i] <= wd3;
        end else if (w_b_en && (wab == ADDR_W'(i))) begin
          r_mem[i] <= wdb;
        end
      end
    end
  end

  // Read muxing: PC alias, clear masking, optional forwarding, then storage
  always_comb begin
    rd = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (ra[p] == PC_IDX) begin
        rd[p] = r15;
      end else if (w_busy) begin
        rd[p] = '0;
      end else if (BYPASS && w_a_en && (wa3 == ra[p])) begin
        rd[p] = wd3;
      end else if (BYPASS && w_b_en && (wab == ra[p])) begin
        rd[p] = wdb;
      end else if (32'(ra[p]) < NUM_STORE) begin
        rd[p] = r_mem[ra[p]];
      end
    end
  end

endmodule
